multiprec_addsub_seq: RTL and testbench

- Multi-cycle sequencer that computes DATA_W-bit add/subtract by pushing operands through one SLICE_W-bit add/sub slice, least-significant slice first.
- Carry is chained between slices through a register.
- Lets a narrow adder such as the 16-bit prefix adder serve wide datapath operations at one slice per clock.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on both sides.

---
 rtl/multiprec_pkg.sv | 20 ++
 rtl/multiprec_addsub_seq_if.sv | 41 ++++
 rtl/addsub_slice.sv | 28 ++
 rtl/multiprec_addsub_seq.sv | 149 ++++++++++++++
 tb/tb_multiprec_addsub_seq.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/multiprec_pkg.sv
// Shared types and defaults for the multi-precision add/sub sequencer.
package multiprec_pkg;

  localparam int unsigned DEF_DATA_W  = 64;
  localparam int unsigned DEF_SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One slice-adder result: sum bits, carry out of the MSB, carry into the MSB
  typedef struct packed {
    logic [DEF_SLICE_W-1:0] s;
    logic                   cout;
    logic                   c_msb;
  } slice_res_t;

endpackage

// File: rtl/multiprec_addsub_seq_if.sv
// Operand/result handshake bundle for multiprec_addsub_seq.
// With STATUS_FLAGS_EN defined, the ovf and zero status lines are added.
interface multiprec_addsub_seq_if
  import multiprec_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              sub;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] sum;
  logic              cout;
`ifdef STATUS_FLAGS_EN
  logic              ovf;
  logic              zero;
`endif

  // Producer/consumer side
  modport master (
    output in_valid, a, b, sub, out_ready,
`ifdef STATUS_FLAGS_EN
    input  ovf, zero,
`endif
    input  in_ready, out_valid, sum, cout
  );

  // Sequencer side
  modport slave (
    input  in_valid, a, b, sub, out_ready,
`ifdef STATUS_FLAGS_EN
    output ovf, zero,
`endif
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/addsub_slice.sv
// Combinational SLICE_W-bit ripple slice; exposes the carry into the MSB
// so a signed-overflow flag can be formed. Any adder with the same ports
// can replace it.
module addsub_slice
  import multiprec_pkg::*;
#(
  parameter int unsigned SLICE_W = DEF_SLICE_W
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout,
  output logic               c_msb
);

  logic [SLICE_W-2:0] lo;
  logic               hi;

  // Lower bits produce the carry into the MSB
  assign {c_msb, lo} = {1'b0, a[SLICE_W-2:0]} + {1'b0, b[SLICE_W-2:0]} + SLICE_W'(cin);

  // MSB produces the slice carry-out
  assign {cout, hi} = 2'(a[SLICE_W-1]) + 2'(b[SLICE_W-1]) + 2'(c_msb);

  assign s = {hi, lo};

endmodule

// File: rtl/multiprec_addsub_seq.sv
// DATA_W-bit add/subtract computed one SLICE_W slice per clock, LS slice
// first, carry chained through a register. Slice width follows
// multiprec_pkg::DEF_SLICE_W because the slice result struct lives there.
// Optional STATUS_FLAGS_EN adds registered ovf and zero outputs.
module multiprec_addsub_seq
  import multiprec_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned SLICE_W = DEF_SLICE_W
) (
  input logic                  clk,
  input logic                  rst_n,
  multiprec_addsub_seq_if.slave bus
);

  localparam int unsigned NSLICE = DATA_W / SLICE_W;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  state_t             state;
  state_t             next_state;
  logic               in_ready_d;
  logic               out_valid_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic [DATA_W-1:0]  sum_q;
  logic               cout_q;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic               last_c;
  slice_res_t         res;

  assign last_c = (cnt == LAST);
  assign a_sl   = op_a[32'(cnt)*SLICE_W +: SLICE_W];
  assign b_sl   = op_b[32'(cnt)*SLICE_W +: SLICE_W];

  addsub_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a     (a_sl),
    .b     (b_sl),
    .cin   (carry),
    .s     (res.s),
    .cout  (res.cout),
    .c_msb (res.c_msb)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.in_valid) next_state = RUN;
      RUN:     if (last_c)       next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs, decoded from the upcoming state and registered below
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (next_state)
      IDLE:    in_ready_d  = 1'b1;
      DONE:    out_valid_d = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, slice accumulation and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      carry       <= 1'b0;
      cnt         <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      case (state)
        IDLE: if (bus.in_valid) begin
          op_a  <= bus.a;
          op_b  <= bus.sub ? ~bus.b : bus.b;
          carry <= bus.sub;
          cnt   <= '0;
        end
        RUN: begin
          sum_q[32'(cnt)*SLICE_W +: SLICE_W] <= res.s;
          carry <= res.cout;
          cnt   <= cnt + CNT_W'(1);
          if (last_c) cout_q <= res.cout;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

`ifdef STATUS_FLAGS_EN
  logic ovf_q;
  logic zero_q;
  logic zacc;

  // Signed overflow and zero detect, settled on the last slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      zacc   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) zacc <= 1'b1;
        RUN: begin
          zacc <= zacc & (res.s == '0);
          if (last_c) begin
            ovf_q  <= res.c_msb ^ res.cout;
            zero_q <= zacc & (res.s == '0);
          end
        end
        DONE: if (bus.out_ready) zero_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
`else
  logic unused_c_msb;
  assign unused_c_msb = res.c_msb;
`endif

endmodule

// File: tb/tb_multiprec_addsub_seq.sv
// Directed bench for multiprec_addsub_seq (64-bit, 16-bit slices).
module tb_multiprec_addsub_seq;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   cyc;

  multiprec_addsub_seq_if #(.DATA_W(64)) bus ();

  multiprec_addsub_seq #(.DATA_W(64), .SLICE_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b, input logic s);
    logic [63:0] bb;
    bb = s ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + 65'(s);
  endfunction

  // Present a request, scramble inputs after acceptance, wait for out_valid.
  // lat counts cycles from the handshake cycle to the first out_valid cycle.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                          output int lat);
    int n;
    lat = -1;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sub = s; bus.in_valid = 1'b1;
    for (n = 0; n < 20 && !bus.in_ready; n++) @(negedge clk);
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = 64'h5A5A_A5A5_0F0F_F0F0; bus.b = 64'hFFFF_0000_1234_4321; bus.sub = ~s;
    for (lat = 1; lat <= 20; lat++) begin
      if (bus.out_valid) break;
      @(negedge clk);
    end
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.sum !== 64'h0) begin errors++; $display("FAIL reset_sum got=%h exp=0", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
`ifdef STATUS_FLAGS_EN
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b exp=0", bus.zero); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_add_carry();
    int lat;
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL add_latency got=%0d exp=5", lat); end
    checks++; if (bus.sum !== 64'h0) begin errors++; $display("FAIL add_sum got=%h exp=0", bus.sum); end
    checks++; if (bus.cout !== 1'b1) begin errors++; $display("FAIL add_cout got=%b exp=1", bus.cout); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL add_done_in_ready got=%b exp=0", bus.in_ready); end
`ifdef STATUS_FLAGS_EN
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL add_ovf got=%b exp=0", bus.ovf); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL add_zero got=%b exp=1", bus.zero); end
`endif
    finish_op();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_drop_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL add_back_idle got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_sub_borrow();
    int lat;
    start_op(64'h0000_0000_0001_0000, 64'h1, 1'b1, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL borrow_latency got=%0d exp=5", lat); end
    checks++; if (bus.sum !== 64'h0000_0000_0000_FFFF) begin errors++; $display("FAIL borrow_sum got=%h exp=000000000000ffff", bus.sum); end
    checks++; if (bus.cout !== 1'b1) begin errors++; $display("FAIL borrow_cout got=%b exp=1", bus.cout); end
    finish_op();
  endtask

  task automatic test_sub_underflow();
    int lat;
    start_op(64'h0, 64'h1, 1'b1, lat);
    checks++; if (bus.sum !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL under_sum got=%h exp=ffffffffffffffff", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL under_cout got=%b exp=0", bus.cout); end
`ifdef STATUS_FLAGS_EN
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL under_zero got=%b exp=0", bus.zero); end
`endif
    finish_op();
`ifdef STATUS_FLAGS_EN
    start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
    checks++; if (bus.sum !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_sum got=%h exp=8000000000000000", bus.sum); end
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", bus.ovf); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL ovf_cout got=%b exp=0", bus.cout); end
    finish_op();
`endif
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(64'hDEAD_BEEF_DEAD_BEEF, 64'h1234_5678_9ABC_DEF0, 1'b0, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL bp_latency got=%0d exp=5", lat); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.sum !== 64'hF0E2_1568_796A_9DDF) begin errors++; $display("FAIL bp_sum[%0d] got=%h exp=f0e21568796a9ddf", k, bus.sum); end
      checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL bp_cout[%0d] got=%b exp=0", k, bus.cout); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%b exp=1", k, bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", k, bus.in_ready); end
      bus.in_valid = (k != 1);
      bus.a = 64'h1; bus.b = 64'h1; bus.sub = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    finish_op();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop_valid got=%b exp=0", bus.out_valid); end
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_ghost_op got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    bus.a = 64'h5; bus.b = 64'h5; bus.sub = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.sum !== 64'h0) begin errors++; $display("FAIL abort_sum got=%h exp=0", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL abort_cout got=%b exp=0", bus.cout); end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(64'h2, 64'h3, 1'b0, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL post_abort_latency got=%0d exp=5", lat); end
    checks++; if (bus.sum !== 64'h5) begin errors++; $display("FAIL post_abort_sum got=%h exp=5", bus.sum); end
    finish_op();
  endtask

  task automatic test_back_to_back();
    logic [63:0] va[4];
    logic [63:0] vb[4];
    logic        vs[4];
    logic [64:0] exp_v;
    int acc_cyc[4];
    int res_cyc[4];
    int na;
    int nr;
    bit hs;
    va = '{64'h1, 64'h8000_0000_0000_0000, 64'h0000_FFFF_0000_FFFF, 64'h3};
    vb = '{64'h2, 64'h8000_0000_0000_0000, 64'h1, 64'h5};
    vs = '{1'b0, 1'b0, 1'b1, 1'b1};
    na = 0; nr = 0; hs = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.a = va[0]; bus.b = vb[0]; bus.sub = vs[0]; bus.in_valid = 1'b1;
    for (int c = 0; c < 80 && nr < 4; c++) begin
      if (bus.out_valid && bus.out_ready) begin
        exp_v = model(va[nr], vb[nr], vs[nr]);
        checks++; if (bus.sum !== exp_v[63:0]) begin errors++; $display("FAIL b2b_sum[%0d] got=%h exp=%h", nr, bus.sum, exp_v[63:0]); end
        checks++; if (bus.cout !== exp_v[64]) begin errors++; $display("FAIL b2b_cout[%0d] got=%b exp=%b", nr, bus.cout, exp_v[64]); end
        res_cyc[nr] = cyc;
        nr++;
      end
      if (bus.in_valid && bus.in_ready && na < 4) begin
        acc_cyc[na] = cyc;
        na++;
        hs = 1'b1;
      end
      @(negedge clk);
      if (hs) begin
        hs = 1'b0;
        if (na < 4) begin
          bus.a = va[na]; bus.b = vb[na]; bus.sub = vs[na];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (nr !== 4 || na !== 4) begin errors++; $display("FAIL b2b_count results=%0d accepts=%0d exp=4", nr, na); end
    if (nr == 4 && na == 4) begin
      checks++; if (res_cyc[0] - acc_cyc[0] !== 5) begin errors++; $display("FAIL b2b_latency got=%0d exp=5", res_cyc[0] - acc_cyc[0]); end
      for (int i = 1; i < 4; i++) begin
        checks++; if (acc_cyc[i] - acc_cyc[i-1] !== 6) begin errors++; $display("FAIL b2b_accept_gap[%0d] got=%0d exp=6", i, acc_cyc[i] - acc_cyc[i-1]); end
        checks++; if (res_cyc[i] - res_cyc[i-1] !== 6) begin errors++; $display("FAIL b2b_result_gap[%0d] got=%0d exp=6", i, res_cyc[i] - res_cyc[i-1]); end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    test_reset();
    test_add_carry();
    test_sub_borrow();
    test_sub_underflow();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
